md_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the E stage.
- Owns the HI/LO registers and accepts one mult/div/mthi/mtlo operation per start pulse.
- Drives `busy` for a fixed number of cycles per operation, then commits the result to HI/LO.
- The hazard/pause unit consumes `busy` and `start` to hold D while the unit is occupied.

---
 rtl/md_ctrl_pkg.sv | 36 +++
 rtl/md_compute.sv | 71 +++++++
 rtl/md_ctrl.sv | 98 +++++++++
 tb/tb_md_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer: XALUOp codes,
// FSM state encoding, default latencies and op-class helpers.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned DEFAULT_MULT_CYCLES = 5;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

    // Codes 7..15 are reserved and behave exactly like NONE.
    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd6);
    endfunction

    function automatic logic op_is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Purely combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// res_hi/res_lo are meaningful only for the four long operations.
module md_compute
    import md_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] div_den;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // The divider never sees a zero or the INT_MIN/-1 overflow pair; both
    // cases are resolved explicitly so no undefined quotient leaks out.
    assign div_ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign div_by_zero = op_is_div(op) && (b == 32'd0);
    assign div_den     = ((b == 32'd0) || div_ovf) ? 32'd1 : b;

    assign quot_s = $signed(a) / $signed(div_den);
    assign rem_s  = $signed(a) % $signed(div_den);
    assign quot_u = a / div_den;
    assign rem_u  = a % div_den;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            OP_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, holds busy for a fixed
// number of cycles per long operation, then commits the pending result.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_e   state;
    md_state_e   state_next;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_load;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_commit;
    logic        issue;
    logic        long_issue;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_by_zero;

    md_compute u_compute (
        .op          (op),
        .a           (a),
        .b           (b),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // A start while RUN or under cancel is dropped here, never queued.
    assign issue      = start && !cancel && (state == ST_IDLE) && op_is_valid(op);
    assign long_issue = issue && (op_is_mult(op) || op_is_div(op));
    assign cnt_load   = op_is_mult(op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
    assign busy       = (state == ST_RUN);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (long_issue)      state_next = ST_RUN;
            ST_RUN:  if (counter == '0)   state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter     <= '0;
            pend_hi     <= 32'd0;
            pend_lo     <= 32'd0;
            pend_commit <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else if (state == ST_RUN) begin
            if (counter != '0) begin
                counter <= counter - 1'b1;
            end else if (pend_commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (issue) begin
            case (op)
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: begin
                    // Divide-by-zero still runs the full latency but leaves HI/LO alone.
                    pend_hi     <= res_hi;
                    pend_lo     <= res_lo;
                    pend_commit <= !div_by_zero;
                    counter     <= cnt_load;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed cases followed by random ops
// compared against a 64-bit arithmetic reference model of HI/LO and latency.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: new HI/LO from plain 64-bit arithmetic, and busy length.
    task automatic model_op(input logic [3:0] o, input logic [31:0] oa, input logic [31:0] ob,
                            input logic oc, output int n);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(oa));
        sb = longint'($signed(ob));
        ua = {32'd0, oa};
        ub = {32'd0, ob};
        n  = 0;
        if (!oc) begin
            case (o)
                4'd1: begin p = sa * sb; mdl_hi = p[63:32]; mdl_lo = p[31:0]; n = MC; end
                4'd2: begin pu = ua * ub; mdl_hi = pu[63:32]; mdl_lo = pu[31:0]; n = MC; end
                4'd3: begin
                    n = DC;
                    if (ob != 32'd0) begin
                        q = sa / sb; r = sa % sb;
                        mdl_hi = r[31:0]; mdl_lo = q[31:0];
                    end
                end
                4'd4: begin
                    n = DC;
                    if (ob != 32'd0) begin
                        pu = ua / ub; mdl_lo = pu[31:0];
                        pu = ua % ub; mdl_hi = pu[31:0];
                    end
                end
                4'd5: mdl_hi = oa;
                4'd6: mdl_lo = oa;
                default: n = 0;
            endcase
        end
    endtask

    // Starts at a negedge; optionally drives a stray start at busy cycle intr_idx.
    task automatic run_op(input logic [3:0] o, input logic [31:0] oa, input logic [31:0] ob,
                          input logic oc, input int intr_idx, input logic [3:0] intr_op);
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        model_op(o, oa, ob, oc, n);
        start = 1'b1; op = o; a = oa; b = ob; cancel = oc;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("hi_hold", hi, old_hi);
            check("lo_hold", lo, old_lo);
            if (i == intr_idx) begin
                start = 1'b1; op = intr_op; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_done", {31'd0, busy}, 32'd0);
        check("hi_result", hi, mdl_hi);
        check("lo_result", lo, mdl_lo);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        r_c;

        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, 4'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 4'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, 4'd0);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        run_op(4'd4, 32'd7, 32'd2, 1'b0, -1, 4'd0);
        check("divu_hi", hi, 32'd1);
        check("divu_lo", lo, 32'd3);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 4'd0);
        check("divovf_hi", hi, 32'd0);
        check("divovf_lo", lo, 32'h8000_0000);

        run_op(4'd5, 32'h11, 32'd0, 1'b0, -1, 4'd0);
        run_op(4'd6, 32'h22, 32'd0, 1'b0, -1, 4'd0);
        check("mt_hi", hi, 32'h11);
        check("mt_lo", lo, 32'h22);
        run_op(4'd4, 32'd5, 32'd0, 1'b0, -1, 4'd0);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);

        run_op(4'd1, 32'd9, 32'd9, 1'b1, -1, 4'd0);
        check("cancel_hi", hi, 32'h11);
        check("cancel_lo", lo, 32'h22);

        // Stray starts mid-run and on the commit edge must both be ignored.
        run_op(4'd1, 32'd6, 32'd7, 1'b0, 1, 4'd3);
        check("intr_lo", lo, 32'd42);
        run_op(4'd2, 32'd3, 32'd5, 1'b0, MC - 1, 4'd5);
        check("commit_edge_hi", hi, 32'd0);
        check("commit_edge_lo", lo, 32'd15);

        // Reset in the third busy cycle discards the run.
        run_op(4'd5, 32'h55, 32'd0, 1'b0, -1, 4'd0);
        run_op(4'd6, 32'h66, 32'd0, 1'b0, -1, 4'd0);
        start = 1'b1; op = 4'd1; a = 32'd100; b = 32'd100; cancel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        for (int i = 0; i < MC + 3; i++) begin
            @(negedge clk);
            check("postrst_busy", {31'd0, busy}, 32'd0);
            check("postrst_lo", lo, 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r_op = 4'($urandom_range(1, 6));
            r_a = $urandom;
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            r_c = ($urandom_range(0, 7) == 0);
            run_op(r_op, r_a, r_b, r_c, -1, 4'd0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
